// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - request/result handshake bundle between the execute stage and muldiv_seq
interface muldiv_seq_if #(
    parameter int XLEN = 64
) ();
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] c;
    logic            busy;
    logic            flush;

    modport master (
        output in_valid, op, a, b, out_ready, flush,
        input  in_ready, out_valid, c, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready, flush,
        output in_ready, out_valid, c, busy
    );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle RV64M MUL/DIV/DIVU/REM/REMU sequencer (shift-add / restoring divide)
module muldiv_seq #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic          clk,
    input  logic          resetn,
    muldiv_seq_if.slave   bus
);
    localparam logic [2:0] OP_MUL  = 3'd0;
    localparam logic [2:0] OP_DIV  = 3'd1;
    localparam logic [2:0] OP_DIVU = 3'd2;
    localparam logic [2:0] OP_REM  = 3'd3;
    localparam logic [2:0] OP_REMU = 3'd4;

    localparam logic [XLEN-1:0] ONES    = '1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            state, state_nx;
    logic [2:0]        op_q;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   x_q;     // multiplicand (MUL) or divisor
    logic [XLEN-1:0]   y_q;     // multiplier (MUL) or dividend/quotient
    logic [XLEN-1:0]   rem_q;   // product accumulator (MUL) or remainder
    logic              neg_q, neg_r;
    logic [XLEN-1:0]   c_q;

    logic              accept;
    logic              in_signed, in_div, in_illegal, div_zero, div_ovf, special;
    logic [XLEN-1:0]   a_abs, b_abs, special_c;

    logic [XLEN-1:0]   mul_sum;
    logic [XLEN:0]     rem_sh, rem_sub;
    logic              ge;
    logic [XLEN-1:0]   rem_nx, quot_nx, result;

    assign bus.in_ready  = (state == S_IDLE) && !bus.flush;
    assign bus.out_valid = (state == S_DONE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.c         = c_q;

    assign accept = bus.in_valid && bus.in_ready;

    // Request decode: operand magnitudes and the cases answered without iterating
    always_comb begin
        in_signed  = (bus.op == OP_DIV) || (bus.op == OP_REM);
        in_div     = (bus.op >= OP_DIV) && (bus.op <= OP_REMU);
        in_illegal = (bus.op > OP_REMU);
        div_zero   = in_div && (bus.b == '0);
        div_ovf    = in_signed && (bus.a == INT_MIN) && (bus.b == ONES);
        special    = in_illegal || div_zero || div_ovf;
        a_abs      = (in_signed && bus.a[XLEN-1]) ? -bus.a : bus.a;
        b_abs      = (in_signed && bus.b[XLEN-1]) ? -bus.b : bus.b;
        special_c  = '0;
        if (in_illegal)
            special_c = '0;
        else if (div_zero)
            special_c = ((bus.op == OP_DIV) || (bus.op == OP_DIVU)) ? ONES : bus.a;
        else if (div_ovf)
            special_c = (bus.op == OP_DIV) ? bus.a : '0;
    end

    // One iteration of either engine; the borrow of rem_sub is the compare result
    always_comb begin
        mul_sum = rem_q + (y_q[0] ? x_q : '0);
        rem_sh  = {rem_q, y_q[XLEN-1]};
        rem_sub = rem_sh - {1'b0, x_q};
        ge      = !rem_sub[XLEN];
        rem_nx  = ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
        quot_nx = {y_q[XLEN-2:0], ge};
        case (op_q)
            OP_MUL:  result = rem_q;
            OP_DIV:  result = neg_q ? -y_q : y_q;
            OP_DIVU: result = y_q;
            OP_REM:  result = neg_r ? -rem_q : rem_q;
            default: result = rem_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = special ? S_DONE : S_BUSY;
            S_BUSY: begin
                if (bus.flush)
                    state_nx = S_IDLE;
                else if (cnt == '0)
                    state_nx = S_DONE;
            end
            S_DONE: if (bus.flush || bus.out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // The edge after the last iteration registers c with sign correction applied
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q  <= '0;
            cnt   <= '0;
            x_q   <= '0;
            y_q   <= '0;
            rem_q <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            c_q   <= '0;
        end else if (accept) begin
            op_q  <= bus.op;
            cnt   <= CNT_W'(XLEN);
            rem_q <= '0;
            neg_q <= in_signed && (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
            neg_r <= in_signed && bus.a[XLEN-1];
            if (bus.op == OP_MUL) begin
                x_q <= bus.a;
                y_q <= bus.b;
            end else begin
                x_q <= b_abs;
                y_q <= a_abs;
            end
            if (special)
                c_q <= special_c;
        end else if (state == S_BUSY && !bus.flush) begin
            if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
                if (op_q == OP_MUL) begin
                    rem_q <= mul_sum;
                    x_q   <= {x_q[XLEN-2:0], 1'b0};
                    y_q   <= {1'b0, y_q[XLEN-1:1]};
                end else begin
                    rem_q <= rem_nx;
                    y_q   <= quot_nx;
                end
            end else begin
                c_q <= result;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq against an arithmetic reference model
module tb_muldiv_seq;
    localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;

    logic clk;
    logic resetn;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;

    muldiv_seq_if #(.XLEN(64)) bus ();

    muldiv_seq #(.XLEN(64), .CNT_W(7)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic is_special(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        if (op > 3'd4) return 1'b1;
        if (op != 3'd0 && b == 64'd0) return 1'b1;
        if ((op == 3'd1 || op == 3'd3) && a == INT_MIN && b == ONES) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [63:0] ref_c(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        longint sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd0: return a * b;
            3'd1: begin
                if (b == 64'd0) return ONES;
                if (a == INT_MIN && b == ONES) return a;
                return 64'(sa / sb);
            end
            3'd2: return (b == 64'd0) ? ONES : a / b;
            3'd3: begin
                if (b == 64'd0) return a;
                if (a == INT_MIN && b == ONES) return 64'd0;
                return 64'(sa % sb);
            end
            3'd4: return (b == 64'd0) ? a : a % b;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return {$urandom, $urandom};
            1: return 64'($urandom_range(0, 20));
            2: return 64'd0;
            3: return INT_MIN;
            4: return ONES;
            default: return -64'($urandom_range(1, 20));
        endcase
    endfunction

    // Present a request, complete the accept edge, then scramble the now-ignored inputs
    task automatic start_op(input string tag, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a  = a;
        bus.b  = b;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.op = 3'($urandom_range(0, 7));
        bus.a  = {$urandom, $urandom};
        bus.b  = {$urandom, $urandom};
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!bus.out_valid && k < 200) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        int k;
        logic [63:0] exp_c;
        int exp_k;
        exp_c = ref_c(op, a, b);
        exp_k = is_special(op, a, b) ? 0 : 65;
        start_op(tag, op, a, b);
        wait_valid(k);
        chk({tag, ".latency"}, 64'(k), 64'(exp_k));
        chk({tag, ".c"}, bus.c, exp_c);
        chk({tag, ".busy"}, 64'(bus.busy), 64'd1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, ".valid_drop"}, 64'(bus.out_valid), 64'd0);
        chk({tag, ".ready_back"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        int k;
        int seen;
        logic [63:0] held;
        logic [2:0] rop;

        resetn = 1'b0;
        bus.in_valid = 1'b0;
        bus.op = 3'd0;
        bus.a = 64'd0;
        bus.b = 64'd0;
        bus.out_ready = 1'b0;
        bus.flush = 1'b0;
        #3;
        chk("reset.out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset.busy", 64'(bus.busy), 64'd0);
        chk("reset.in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset.c", bus.c, 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        run_op("mul_7x6", 3'd0, 64'd7, 64'd6);
        run_op("mul_m1x3", 3'd0, ONES, 64'd3);
        run_op("div_m7_2", 3'd1, -64'd7, 64'd2);
        run_op("rem_m7_2", 3'd3, -64'd7, 64'd2);
        run_op("divu_100_7", 3'd2, 64'd100, 64'd7);
        run_op("remu_100_7", 3'd4, 64'd100, 64'd7);
        run_op("divu_by0", 3'd2, 64'd5, 64'd0);
        run_op("rem_by0", 3'd3, 64'd5, 64'd0);
        run_op("div_ovf", 3'd1, INT_MIN, ONES);
        run_op("rem_ovf", 3'd3, INT_MIN, ONES);
        run_op("illegal", 3'd6, 64'd12, 64'd3);

        // Backpressure: result held for 10 cycles with out_ready low
        start_op("bp", 3'd0, 64'd123456789, 64'd987654321);
        wait_valid(k);
        chk("bp.latency", 64'(k), 64'd65);
        held = bus.c;
        chk("bp.c", held, 64'd123456789 * 64'd987654321);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp.c_stable", bus.c, held);
            chk("bp.valid_held", 64'(bus.out_valid), 64'd1);
            chk("bp.busy", 64'(bus.busy), 64'd1);
            chk("bp.in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp.idle_valid", 64'(bus.out_valid), 64'd0);
        chk("bp.idle_busy", 64'(bus.busy), 64'd0);
        chk("bp.idle_ready", 64'(bus.in_ready), 64'd1);

        // Flush 20 cycles into a DIV, with a competing request that must be ignored
        start_op("fl", 3'd1, 64'd1_000_000_007, 64'd13);
        repeat (19) @(negedge clk);
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.op = 3'd0;
        chk("fl.in_ready_busy", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("fl.idle_valid", 64'(bus.out_valid), 64'd0);
        chk("fl.idle_busy", 64'(bus.busy), 64'd0);
        chk("fl.in_ready_flush", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("fl.req_rejected", 64'(bus.busy), 64'd0);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("fl.no_valid", 64'(seen), 64'd0);
        run_op("fl.mul_3x5", 3'd0, 64'd3, 64'd5);

        // Flush beats out_ready in DONE
        start_op("fd", 3'd2, 64'd5, 64'd0);
        chk("fd.valid", 64'(bus.out_valid), 64'd1);
        bus.flush = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        chk("fd.valid_drop", 64'(bus.out_valid), 64'd0);
        chk("fd.busy", 64'(bus.busy), 64'd0);

        // Asynchronous reset in the middle of BUSY
        start_op("rst", 3'd2, {$urandom, $urandom}, 64'd77);
        repeat (10) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.busy", 64'(bus.busy), 64'd0);
        chk("rst.in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst.c", bus.c, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_op("rst.divu_9_3", 3'd2, 64'd9, 64'd3);

        for (int i = 0; i < 30; i++) begin
            rop = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            run_op($sformatf("rnd%0d", i), rop, pick_operand(), pick_operand());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
